// File: rtl/exe_fwd_stage.sv
// Execute stage with MEM/WB operand bypass, single-cycle ALU and a multi-cycle
// signed multiplier that writes HI/LO; result is registered into the EX/MEM slot.
module exe_fwd_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [3:0]        alu_op,
  input  logic              alu_src,
  input  logic [15:0]       imm16,
  input  logic [4:0]        shamt,
  input  logic [REG_AW-1:0] rs_idx,
  input  logic [REG_AW-1:0] rt_idx,
  input  logic [REG_AW-1:0] rd_idx,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              wb_en_in,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_fwd_idx,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_idx,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wb_en,
  output logic              out_mem_rd,
  output logic              out_mem_wr
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSlt  = 4'd5;
  localparam logic [3:0] OpSll  = 4'd6;
  localparam logic [3:0] OpSrl  = 4'd7;
  localparam logic [3:0] OpMult = 4'd8;
  localparam logic [3:0] OpMfhi = 4'd9;
  localparam logic [3:0] OpMflo = 4'd10;

  localparam int unsigned CntW = $clog2(MUL_LAT);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d;
  logic [DATA_W-1:0]   mul_b_q, mul_b_d;

  logic                out_valid_d;
  logic [DATA_W-1:0]   out_result_d;
  logic [DATA_W-1:0]   out_store_data_d;
  logic [REG_AW-1:0]   out_rd_d;
  logic                out_wb_en_d;
  logic                out_mem_rd_d;
  logic                out_mem_wr_d;

  logic [DATA_W-1:0]   fwd_rs;
  logic [DATA_W-1:0]   fwd_rt;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   alu_res;
  logic [2*DATA_W-1:0] prod;
  logic                is_mul_op;
  logic                issue;

  // Bypass priority: youngest producer (MEM) first; register 0 is never forwarded.
  always_comb begin
    fwd_rs = rs_val;
    if (mem_fwd_en && (mem_fwd_idx == rs_idx) && (rs_idx != '0)) begin
      fwd_rs = mem_fwd_data;
    end else if (wb_fwd_en && (wb_fwd_idx == rs_idx) && (rs_idx != '0)) begin
      fwd_rs = wb_fwd_data;
    end
  end

  always_comb begin
    fwd_rt = rt_val;
    if (mem_fwd_en && (mem_fwd_idx == rt_idx) && (rt_idx != '0)) begin
      fwd_rt = mem_fwd_data;
    end else if (wb_fwd_en && (wb_fwd_idx == rt_idx) && (rt_idx != '0)) begin
      fwd_rt = wb_fwd_data;
    end
  end

  assign imm_ext = DATA_W'($signed(imm16));
  assign op_a    = fwd_rs;
  assign op_b    = alu_src ? imm_ext : fwd_rt;

  assign is_mul_op = (alu_op == OpMult) || (alu_op == OpMfhi) || (alu_op == OpMflo);
  assign stall     = in_valid && (state_q == StBusy) && is_mul_op;
  assign issue     = in_valid && !stall && !flush;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpXor:   alu_res = op_a ^ op_b;
      OpSlt:   alu_res = DATA_W'($signed(op_a) < $signed(op_b));
      OpSll:   alu_res = op_b << shamt;
      OpSrl:   alu_res = op_b >> shamt;
      OpMfhi:  alu_res = hi_q;
      OpMflo:  alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Sign-extend both captured operands so the low 2*DATA_W bits are the signed product.
  assign prod = {{DATA_W{mul_a_q[DATA_W-1]}}, mul_a_q} * {{DATA_W{mul_b_q[DATA_W-1]}}, mul_b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue && (alu_op == OpMult)) begin
            state_d = StBusy;
            cnt_d   = CntW'(MUL_LAT - 1);
            mul_a_d = op_a;
            mul_b_d = op_b;
          end
        end
        StBusy: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            hi_d    = prod[2*DATA_W-1:DATA_W];
            lo_d    = prod[DATA_W-1:0];
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Bubbles carry all-zero control so nothing downstream acts on stale bits.
  always_comb begin
    out_valid_d      = 1'b0;
    out_result_d     = '0;
    out_store_data_d = '0;
    out_rd_d         = '0;
    out_wb_en_d      = 1'b0;
    out_mem_rd_d     = 1'b0;
    out_mem_wr_d     = 1'b0;
    if (issue) begin
      out_valid_d      = 1'b1;
      out_result_d     = (alu_op == OpMult) ? '0 : alu_res;
      out_store_data_d = fwd_rt;
      out_rd_d         = rd_idx;
      out_wb_en_d      = wb_en_in && (alu_op != OpMult);
      out_mem_rd_d     = mem_rd_in;
      out_mem_wr_d     = mem_wr_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_wb_en      <= 1'b0;
      out_mem_rd     <= 1'b0;
      out_mem_wr     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      out_valid      <= out_valid_d;
      out_result     <= out_result_d;
      out_store_data <= out_store_data_d;
      out_rd         <= out_rd_d;
      out_wb_en      <= out_wb_en_d;
      out_mem_rd     <= out_mem_rd_d;
      out_mem_wr     <= out_mem_wr_d;
    end
  end

endmodule

// File: tb/tb_exe_fwd_stage.sv
// Scoreboard bench for exe_fwd_stage: directed vectors push expected slots,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_exe_fwd_stage;

  logic        CLK;
  logic        RESET;
  logic        in_valid;
  logic        flush;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [15:0] imm16;
  logic [4:0]  shamt;
  logic [4:0]  rs_idx, rt_idx, rd_idx;
  logic [31:0] rs_val, rt_val;
  logic        wb_en_in, mem_rd_in, mem_wr_in;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_idx, wb_fwd_idx;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_wb_en, out_mem_rd, out_mem_wr;

  exe_fwd_stage #(
    .DATA_W (32),
    .REG_AW (5),
    .MUL_LAT(4)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .in_valid      (in_valid),
    .flush         (flush),
    .alu_op        (alu_op),
    .alu_src       (alu_src),
    .imm16         (imm16),
    .shamt         (shamt),
    .rs_idx        (rs_idx),
    .rt_idx        (rt_idx),
    .rd_idx        (rd_idx),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .wb_en_in      (wb_en_in),
    .mem_rd_in     (mem_rd_in),
    .mem_wr_in     (mem_wr_in),
    .mem_fwd_en    (mem_fwd_en),
    .mem_fwd_idx   (mem_fwd_idx),
    .mem_fwd_data  (mem_fwd_data),
    .wb_fwd_en     (wb_fwd_en),
    .wb_fwd_idx    (wb_fwd_idx),
    .wb_fwd_data   (wb_fwd_data),
    .stall         (stall),
    .out_valid     (out_valid),
    .out_result    (out_result),
    .out_store_data(out_store_data),
    .out_rd        (out_rd),
    .out_wb_en     (out_wb_en),
    .out_mem_rd    (out_mem_rd),
    .out_mem_wr    (out_mem_wr)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        wb;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got out_valid=1 result 0x%08h required no output",
                 out_result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_store_data", out_store_data, e.st);
        chk("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
        chk("out_wb_en", {31'b0, out_wb_en}, {31'b0, e.wb});
        chk("out_mem_ctl", {30'b0, out_mem_rd, out_mem_wr}, {30'b0, e.mr, e.mw});
      end
    end
  end

  task automatic set_op(input logic [3:0] op, input logic src, input logic [15:0] imm,
                        input logic [4:0] sh, input logic [4:0] rsi, input logic [4:0] rti,
                        input logic [4:0] rdi, input logic [31:0] rsv, input logic [31:0] rtv);
    in_valid  = 1'b1;
    alu_op    = op;
    alu_src   = src;
    imm16     = imm;
    shamt     = sh;
    rs_idx    = rsi;
    rt_idx    = rti;
    rd_idx    = rdi;
    rs_val    = rsv;
    rt_val    = rtv;
    wb_en_in  = 1'b1;
    mem_rd_in = 1'b0;
    mem_wr_in = 1'b0;
  endtask

  // Called at posedge+1 with inputs set; expects acceptance at the coming edge.
  task automatic issue(input string name, input logic [31:0] res, input logic [31:0] st,
                       input logic wb);
    exp_t e;
    #1;
    chk({name, "_stall"}, {31'b0, stall}, 32'd0);
    e.res = res;
    e.st  = st;
    e.rd  = rd_idx;
    e.wb  = wb;
    e.mr  = mem_rd_in;
    e.mw  = mem_wr_in;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic fwd_off();
    mem_fwd_en   = 1'b0;
    mem_fwd_idx  = 5'd0;
    mem_fwd_data = 32'd0;
    wb_fwd_en    = 1'b0;
    wb_fwd_idx   = 5'd0;
    wb_fwd_data  = 32'd0;
  endtask

  task automatic wait_unstall(input string name);
    int n;
    n = 0;
    #1;
    while (stall && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got stall=1 after 20 cycles required stall=0", name);
    end
  endtask

  initial begin
    RESET = 1'b0;
    flush = 1'b0;
    fwd_off();
    set_op(4'd8, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_store", out_store_data, 32'd0);
    chk("rst_out_ctl", {26'b0, out_rd, out_wb_en, out_mem_rd, out_mem_wr}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    in_valid = 1'b0;
    RESET    = 1'b1;
    @(posedge CLK);
    #1;

    // Bypass priority and the register-0 rule
    mem_fwd_en = 1'b1; mem_fwd_idx = 5'd3; mem_fwd_data = 32'd7;
    wb_fwd_en  = 1'b1; wb_fwd_idx  = 5'd3; wb_fwd_data  = 32'd9;
    set_op(4'd0, 1'b0, 16'h0, 5'd0, 5'd3, 5'd4, 5'd8, 32'd5, 32'd1);
    issue("fwd_mem", 32'd8, 32'd1, 1'b1);
    mem_fwd_idx = 5'd6;
    set_op(4'd0, 1'b0, 16'h0, 5'd0, 5'd3, 5'd4, 5'd8, 32'd5, 32'd1);
    issue("fwd_wb", 32'd10, 32'd1, 1'b1);
    mem_fwd_idx = 5'd4; mem_fwd_data = 32'd100;
    wb_fwd_idx  = 5'd4; wb_fwd_data  = 32'd50;
    set_op(4'd0, 1'b0, 16'h0, 5'd0, 5'd3, 5'd4, 5'd9, 32'd1, 32'd2);
    issue("fwd_rt", 32'd101, 32'd100, 1'b1);
    fwd_off();
    set_op(4'd0, 1'b1, 16'hFFFF, 5'd0, 5'd2, 5'd5, 5'd10, 32'd10, 32'd33);
    issue("imm_add", 32'd9, 32'd33, 1'b1);
    mem_fwd_en = 1'b1; mem_fwd_idx = 5'd0; mem_fwd_data = 32'd99;
    wb_fwd_en  = 1'b1; wb_fwd_idx  = 5'd0; wb_fwd_data  = 32'd99;
    set_op(4'd0, 1'b1, 16'hFFFF, 5'd0, 5'd0, 5'd0, 5'd11, 32'd10, 32'd7);
    issue("idx0_nofwd", 32'd9, 32'd7, 1'b1);
    fwd_off();

    // ALU op table
    set_op(4'd1, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd12, 32'd5, 32'd7);
    issue("sub_wrap", 32'hFFFF_FFFE, 32'd7, 1'b1);
    set_op(4'd2, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd13, 32'h0000_F0F0, 32'h0000_FF00);
    issue("and", 32'h0000_F000, 32'h0000_FF00, 1'b1);
    set_op(4'd3, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd14, 32'h0000_F0F0, 32'h0000_FF00);
    issue("or", 32'h0000_FFF0, 32'h0000_FF00, 1'b1);
    set_op(4'd4, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd15, 32'h0000_F0F0, 32'h0000_FF00);
    issue("xor", 32'h0000_0FF0, 32'h0000_FF00, 1'b1);
    set_op(4'd5, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd16, 32'hFFFF_FFFF, 32'd1);
    issue("slt_true", 32'd1, 32'd1, 1'b1);
    set_op(4'd5, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd17, 32'd1, 32'hFFFF_FFFF);
    issue("slt_false", 32'd0, 32'hFFFF_FFFF, 1'b1);
    set_op(4'd6, 1'b0, 16'h0, 5'd4, 5'd1, 5'd2, 5'd18, 32'h8000_0001, 32'h8000_0001);
    issue("sll", 32'h0000_0010, 32'h8000_0001, 1'b1);
    set_op(4'd7, 1'b0, 16'h0, 5'd4, 5'd1, 5'd2, 5'd19, 32'h8000_0001, 32'h8000_0001);
    issue("srl", 32'h0800_0000, 32'h8000_0001, 1'b1);
    set_op(4'd11, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd20, 32'd5, 32'd7);
    issue("op11", 32'd0, 32'd7, 1'b1);
    set_op(4'd0, 1'b1, 16'h0004, 5'd0, 5'd1, 5'd2, 5'd21, 32'd100, 32'hDEAD_BEEF);
    wb_en_in  = 1'b0;
    mem_wr_in = 1'b1;
    issue("store", 32'd104, 32'hDEAD_BEEF, 1'b0);

    // MULT -3*4: MFLO stalls three cycles, then HI/LO read back
    set_op(4'd8, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFD, 32'd4);
    issue("mult_neg", 32'd0, 32'd4, 1'b0);
    set_op(4'd10, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd4, 32'd111, 32'd222);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mul_busy_stall", {31'b0, stall}, 32'd1);
      @(posedge CLK);
      #1;
    end
    issue("mflo_neg", 32'hFFFF_FFF4, 32'd222, 1'b1);
    set_op(4'd9, 1'b0, 16'h0, 5'd0, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0);
    issue("mfhi_neg", 32'hFFFF_FFFF, 32'd0, 1'b1);

    // ALU work proceeds while the multiplier is busy
    set_op(4'd8, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'd7, 32'd6);
    issue("mult_7x6", 32'd0, 32'd6, 1'b0);
    set_op(4'd0, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd6, 32'd20, 32'd3);
    issue("add_busy", 32'd23, 32'd3, 1'b1);
    set_op(4'd10, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd7, 32'd0, 32'd0);
    wait_unstall("mflo_7x6");
    issue("mflo_7x6", 32'd42, 32'd0, 1'b1);
    set_op(4'd9, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0);
    issue("mfhi_7x6", 32'd0, 32'd0, 1'b1);

    // Flush mid-multiply: bubble, FSM idle, HI/LO untouched
    set_op(4'd8, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'd100, 32'd100);
    issue("mult_flush", 32'd0, 32'd100, 1'b0);
    set_op(4'd0, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'b0, stall}, 32'd0);
    @(posedge CLK);
    #1;
    flush = 1'b0;
    chk("flush_bubble", {31'b0, out_valid}, 32'd0);
    set_op(4'd10, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd10, 32'd0, 32'd0);
    issue("mflo_flush", 32'd42, 32'd0, 1'b1);
    set_op(4'd9, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd11, 32'd0, 32'd0);
    issue("mfhi_flush", 32'd0, 32'd0, 1'b1);

    // Reset mid-multiply clears outputs and HI/LO
    set_op(4'd8, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd5);
    issue("mult_rst", 32'd0, 32'd5, 1'b0);
    in_valid = 1'b0;
    RESET    = 1'b0;
    @(posedge CLK);
    #1;
    chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_out_result", out_result, 32'd0);
    chk("mrst_out_store", out_store_data, 32'd0);
    chk("mrst_out_ctl", {26'b0, out_rd, out_wb_en, out_mem_rd, out_mem_wr}, 32'd0);
    set_op(4'd10, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd12, 32'd0, 32'd0);
    #1;
    chk("mrst_stall", {31'b0, stall}, 32'd0);
    RESET = 1'b1;
    issue("mflo_rst", 32'd0, 32'd0, 1'b1);
    set_op(4'd9, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd13, 32'd0, 32'd0);
    issue("mfhi_rst", 32'd0, 32'd0, 1'b1);

    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
